// File: rtl/ex_mem_stage_pkg.sv
// EX/MEM stage shared types: FSM encoding and pipeline bundles.
// Structs use the default datapath widths of the core.
package ex_mem_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] alu;
    logic [XLEN_DEF-1:0] wdata;
    logic [RA_W_DEF-1:0] rd;
    logic                RegWrite;
    logic                MemtoReg;
    logic                MemRead;
    logic                MemWrite;
  } exmem_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] alu;
    logic [XLEN_DEF-1:0] mdata;
    logic [RA_W_DEF-1:0] rd;
    logic                RegWrite;
    logic                MemtoReg;
  } memwb_t;

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
  } wbctl_t;

  localparam wbctl_t BUBBLE = '{RegWrite: 1'b0, MemtoReg: 1'b0};

  function automatic logic is_mem(exmem_t e);
    return e.MemRead | e.MemWrite;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Data-memory request/ack bus between the EX/MEM stage and the cache.
// master = pipeline stage, slave = memory.
interface ex_mem_stage_if
  import ex_mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_ack_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_ack_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/mem_access_fsm.sv
// Memory access sequencer: IDLE/BUSY handshake, stall request and
// saturating stall-cycle counter.
module mem_access_fsm
  import ex_mem_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             next_mem,
  input  logic             ack,
  output logic             req,
  output logic             stall,
  output logic             ack_ok,
  output logic [CNT_W-1:0] cnt
);

  state_t state;

  assign req    = (state == BUSY);
  // an ack outside BUSY is stray and must not reach the datapath
  assign ack_ok = req & ack;
  assign stall  = req & ~ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (start) begin
      unique case (state)
        IDLE: state <= next_mem ? BUSY : IDLE;
        BUSY: if (ack) state <= next_mem ? BUSY : IDLE;
      endcase
      if (stall && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM and MEM/WB pipeline registers around the data-memory access.
// stall_o freezes upstream while a memory access waits for ack.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [XLEN-1:0]  ALUResult_i,
  input  logic [XLEN-1:0]  RS2Data_i,
  input  logic [RA_W-1:0]  RDaddr_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  ex_mem_stage_if.master   mem,
  output logic             stall_o,
  output logic [XLEN-1:0]  ALUResult_o,
  output logic [XLEN-1:0]  MemData_o,
  output logic [RA_W-1:0]  RDaddr_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  exmem_t exmem_d;
  exmem_t exmem_q;
  memwb_t memwb_q;
  logic   stall;
  logic   ack_ok;
  logic   unused_ok;

  always_comb begin
    exmem_d          = '0;
    exmem_d.alu      = ALUResult_i;
    exmem_d.wdata    = RS2Data_i;
    exmem_d.rd       = RDaddr_i;
    exmem_d.RegWrite = RegWrite_i;
    exmem_d.MemtoReg = MemtoReg_i;
    exmem_d.MemRead  = MemRead_i;
    exmem_d.MemWrite = MemWrite_i;
  end

  mem_access_fsm #(
    .CNT_W (CNT_W)
  ) u_fsm (
    .clk      (clk_i),
    .rst      (rst_i),
    .start    (start_i),
    .next_mem (is_mem(exmem_d)),
    .ack      (mem.mem_ack_i),
    .req      (mem.mem_req_o),
    .stall    (stall),
    .ack_ok   (ack_ok),
    .cnt      (stall_cnt_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exmem_q <= '0;
      memwb_q <= '0;
    end else if (start_i) begin
      if (!stall) begin
        exmem_q <= exmem_d;
      end
      // a stalled cycle sends a bubble; data fields keep their value
      if (stall) begin
        memwb_q.RegWrite <= BUBBLE.RegWrite;
        memwb_q.MemtoReg <= BUBBLE.MemtoReg;
      end else begin
        memwb_q.alu      <= exmem_q.alu;
        memwb_q.mdata    <= ack_ok ? mem.mem_rdata_i : '0;
        memwb_q.rd       <= exmem_q.rd;
        memwb_q.RegWrite <= exmem_q.RegWrite;
        memwb_q.MemtoReg <= exmem_q.MemtoReg;
      end
    end
  end

  assign mem.mem_we_o    = exmem_q.MemWrite;
  assign mem.mem_addr_o  = exmem_q.alu;
  assign mem.mem_wdata_o = exmem_q.wdata;

  assign stall_o     = stall;
  assign ALUResult_o = memwb_q.alu;
  assign MemData_o   = memwb_q.mdata;
  assign RDaddr_o    = memwb_q.rd;
  assign RegWrite_o  = memwb_q.RegWrite;
  assign MemtoReg_o  = memwb_q.MemtoReg;

  assign unused_ok = exmem_q.MemRead;

endmodule
